// File: rtl/display_cfg_axil_responder_pkg.sv
// Shared constants, state encodings and small helpers for the display config
// AXI4-Lite responder.
package display_cfg_pkg;

   localparam int AXI_ADDR_W = 7;
   localparam int AXI_DATA_W = 32;
   localparam int REG_IDX_W  = 5;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   localparam int STATUS_BUSY_BIT = 10;
   localparam int STATUS_OVR_BIT  = 11;

   typedef enum logic [1:0] {
      W_ADDR = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic {
      R_ADDR = 1'b0,
      R_DATA = 1'b1
   } rd_state_t;

   // Status is read-only: writes to it are slave errors, reads are fine.
   function automatic logic [1:0] decode_resp(input logic [REG_IDX_W-1:0] idx,
                                              input int reg_num,
                                              input int status_idx,
                                              input logic is_write);
      if (int'(idx) >= reg_num)
         return AXI_RESP_DECERR;
      else if (is_write && int'(idx) == status_idx)
         return AXI_RESP_SLVERR;
      else
         return AXI_RESP_OKAY;
   endfunction

   function automatic logic [AXI_DATA_W-1:0] status_word(input logic [AXI_DATA_W-1:0] ext,
                                                         input logic ovr,
                                                         input logic busy);
      logic [AXI_DATA_W-1:0] w;
      w                  = ext;
      w[STATUS_BUSY_BIT] = busy;
      w[STATUS_OVR_BIT]  = ovr;
      return w;
   endfunction

endpackage

// File: rtl/display_cfg_axil_responder_if.sv
// AXI4-Lite bundle between the panel-config master and the config responder.
interface display_cfg_axil_responder_if;
   import display_cfg_pkg::*;

   logic [AXI_ADDR_W-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;
   logic [AXI_DATA_W-1:0] wdata;
   logic                  wvalid;
   logic                  wready;
   logic                  bvalid;
   logic                  bready;
   logic [1:0]            bresp;
   logic [AXI_ADDR_W-1:0] araddr;
   logic                  arvalid;
   logic                  arready;
   logic [AXI_DATA_W-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bvalid, bresp, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/display_cfg_axil_responder_busy_timer.sv
// Busy countdown after each data-register write; flags overrun when a new
// write lands while the previous one is still being absorbed.
module display_cfg_busy_timer #(
   parameter int BUSY_CYCLES = 8
) (
   input  logic i_axi_clk,
   input  logic i_rst,
   input  logic load,
   output logic busy,
   output logic overrun
);

   localparam int CNT_W = (BUSY_CYCLES < 1) ? 1 : $clog2(BUSY_CYCLES + 1);

   logic [CNT_W-1:0] cnt;
   logic             load_while_busy;

   assign busy            = (cnt != '0);
   assign load_while_busy = load && busy;

   // Reload beats decrement; overrun clears on the edge the count hits zero.
   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt     <= '0;
         overrun <= 1'b0;
      end else if (load) begin
         cnt <= CNT_W'(BUSY_CYCLES);
         if (load_while_busy)
            overrun <= 1'b1;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1))
            overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/display_cfg_axil_responder.sv
// AXI4-Lite config register bank for the display/DSI controller: independent
// write (AW->W->B) and read (AR->R) FSMs over a word-indexed register array.
module display_cfg_axil_responder
   import display_cfg_pkg::*;
#(
   parameter int REG_NUM     = 32,
   parameter int STATUS_IDX  = 9,
   parameter int BUSY_CYCLES = 8
) (
   input  logic                         i_axi_clk,
   input  logic                         i_rst,
   display_cfg_axil_responder_if.slave  axi,
   input  logic [AXI_DATA_W-1:0]        i_status,
   output logic                         o_reg_we,
   output logic [REG_IDX_W-1:0]         o_reg_idx,
   output logic [AXI_DATA_W-1:0]        o_reg_wdata,
   output logic                         o_busy
);

   logic [AXI_DATA_W-1:0] regs [REG_NUM];

   logic busy, overrun;
   logic unused_addr_lsbs;
   assign unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};

   // ---------------- write channel ----------------
   wr_state_t            wr_state, wr_state_n;
   logic [REG_IDX_W-1:0] aw_idx, aw_idx_n;
   logic                 awready_n, wready_n, bvalid_n;
   logic [1:0]           bresp_n, wr_resp;
   logic                 commit, wr_ok;

   assign wr_resp = decode_resp(aw_idx, REG_NUM, STATUS_IDX, 1'b1);
   assign wr_ok   = commit && (wr_resp == AXI_RESP_OKAY);

   always_comb begin
      wr_state_n = wr_state;
      aw_idx_n   = aw_idx;
      awready_n  = axi.awready;
      wready_n   = axi.wready;
      bvalid_n   = axi.bvalid;
      bresp_n    = axi.bresp;
      commit     = 1'b0;
      case (wr_state)
         W_ADDR: begin
            awready_n = 1'b1;
            if (axi.awvalid && axi.awready) begin
               aw_idx_n   = axi.awaddr[6:2];
               awready_n  = 1'b0;
               wready_n   = 1'b1;
               wr_state_n = W_DATA;
            end
         end
         W_DATA: begin
            if (axi.wvalid && axi.wready) begin
               commit     = 1'b1;
               wready_n   = 1'b0;
               bvalid_n   = 1'b1;
               bresp_n    = wr_resp;
               wr_state_n = W_RESP;
            end
         end
         W_RESP: begin
            if (axi.bvalid && axi.bready) begin
               bvalid_n   = 1'b0;
               awready_n  = 1'b1;
               wr_state_n = W_ADDR;
            end
         end
         default: wr_state_n = W_ADDR;
      endcase
   end

   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_state    <= W_ADDR;
         aw_idx      <= '0;
         axi.awready <= 1'b0;
         axi.wready  <= 1'b0;
         axi.bvalid  <= 1'b0;
         axi.bresp   <= AXI_RESP_OKAY;
      end else begin
         wr_state    <= wr_state_n;
         aw_idx      <= aw_idx_n;
         axi.awready <= awready_n;
         axi.wready  <= wready_n;
         axi.bvalid  <= bvalid_n;
         axi.bresp   <= bresp_n;
      end
   end

   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < REG_NUM; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < REG_NUM; i++)
            if (aw_idx == REG_IDX_W'(i))
               regs[i] <= axi.wdata;
      end
   end

   // Strobe mirrors the committed write for one cycle; idx/data hold after.
   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         o_reg_we    <= 1'b0;
         o_reg_idx   <= '0;
         o_reg_wdata <= '0;
      end else begin
         o_reg_we <= wr_ok;
         if (wr_ok) begin
            o_reg_idx   <= aw_idx;
            o_reg_wdata <= axi.wdata;
         end
      end
   end

   display_cfg_busy_timer #(
      .BUSY_CYCLES (BUSY_CYCLES)
   ) u_busy_timer (
      .i_axi_clk (i_axi_clk),
      .i_rst     (i_rst),
      .load      (wr_ok),
      .busy      (busy),
      .overrun   (overrun)
   );

   assign o_busy = busy;

   // ---------------- read channel ----------------
   rd_state_t             rd_state, rd_state_n;
   logic [REG_IDX_W-1:0]  rd_idx;
   logic [AXI_DATA_W-1:0] rd_word, rdata_n;
   logic [1:0]            rresp_n;
   logic                  arready_n, rvalid_n;

   assign rd_idx = axi.araddr[6:2];

   // Sampled from pre-edge state, so a same-cycle write returns the old value.
   always_comb begin
      rd_word = '0;
      if (int'(rd_idx) == STATUS_IDX) begin
         rd_word = status_word(i_status, overrun, busy);
      end else begin
         for (int i = 0; i < REG_NUM; i++)
            if (rd_idx == REG_IDX_W'(i))
               rd_word = regs[i];
      end
   end

   always_comb begin
      rd_state_n = rd_state;
      arready_n  = axi.arready;
      rvalid_n   = axi.rvalid;
      rdata_n    = axi.rdata;
      rresp_n    = axi.rresp;
      case (rd_state)
         R_ADDR: begin
            arready_n = 1'b1;
            if (axi.arvalid && axi.arready) begin
               arready_n  = 1'b0;
               rvalid_n   = 1'b1;
               rdata_n    = rd_word;
               rresp_n    = decode_resp(rd_idx, REG_NUM, STATUS_IDX, 1'b0);
               rd_state_n = R_DATA;
            end
         end
         R_DATA: begin
            if (axi.rvalid && axi.rready) begin
               rvalid_n   = 1'b0;
               arready_n  = 1'b1;
               rd_state_n = R_ADDR;
            end
         end
         default: rd_state_n = R_ADDR;
      endcase
   end

   always_ff @(posedge i_axi_clk or posedge i_rst) begin
      if (i_rst) begin
         rd_state    <= R_ADDR;
         axi.arready <= 1'b0;
         axi.rvalid  <= 1'b0;
         axi.rdata   <= '0;
         axi.rresp   <= AXI_RESP_OKAY;
      end else begin
         rd_state    <= rd_state_n;
         axi.arready <= arready_n;
         axi.rvalid  <= rvalid_n;
         axi.rdata   <= rdata_n;
         axi.rresp   <= rresp_n;
      end
   end

endmodule

// File: tb/tb_display_cfg_axil_responder.sv
// Directed bench for the display config AXI4-Lite responder (REG_NUM=16).
module tb_display_cfg_axil_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] status = 32'h0;
   logic        reg_we;
   logic [4:0]  reg_idx;
   logic [31:0] reg_wdata;
   logic        busy;

   int tests = 0;
   int fails = 0;

   display_cfg_axil_responder_if axi ();

   display_cfg_axil_responder #(
      .REG_NUM     (16),
      .STATUS_IDX  (9),
      .BUSY_CYCLES (8)
   ) dut (
      .i_axi_clk   (clk),
      .i_rst       (rst),
      .axi         (axi),
      .i_status    (status),
      .o_reg_we    (reg_we),
      .o_reg_idx   (reg_idx),
      .o_reg_wdata (reg_wdata),
      .o_busy      (busy)
   );

   always #5 clk = ~clk;

   // Passive monitor: strobe count and length of each busy run.
   int          we_cnt = 0;
   logic [4:0]  we_idx = '0;
   logic [31:0] we_data = '0;
   int          busy_run = 0;
   int          busy_len = 0;
   int          busy_falls = 0;

   always @(negedge clk) begin
      if (reg_we) begin
         we_cnt  = we_cnt + 1;
         we_idx  = reg_idx;
         we_data = reg_wdata;
      end
      if (busy) busy_run = busy_run + 1;
      else if (busy_run != 0) begin
         busy_len   = busy_run;
         busy_run   = 0;
         busy_falls = busy_falls + 1;
      end
   end

   // Transaction drivers: start and end on a negedge; handshakes are decided
   // from the values visible before the coming posedge.
   task automatic axi_write(input logic [6:0] addr, input logic [31:0] data,
                            output logic [1:0] resp, output int aw_edge, output int b_edge);
      int  k = 0;
      bit  done = 0;
      bit  hs_aw, hs_w, hs_b;
      resp = 2'b01; aw_edge = -1; b_edge = -1;
      axi.awaddr = addr; axi.awvalid = 1'b1;
      axi.wdata  = data; axi.wvalid  = 1'b1;
      axi.bready = 1'b1;
      while (!done && k < 40) begin
         hs_aw = axi.awvalid && axi.awready;
         hs_w  = axi.wvalid && axi.wready;
         hs_b  = axi.bvalid && axi.bready;
         if (hs_b) resp = axi.bresp;
         @(posedge clk); k++;
         if (hs_aw) aw_edge = k;
         if (hs_b)  b_edge = k;
         @(negedge clk);
         if (hs_aw) axi.awvalid = 1'b0;
         if (hs_w)  axi.wvalid = 1'b0;
         if (hs_b) begin axi.bready = 1'b0; done = 1; end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL write_timeout addr=%h: no B response within 40 cycles", addr);
         axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      end
   endtask

   task automatic axi_read(input logic [6:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int  k = 0;
      bit  done = 0;
      bit  hs_ar, hs_r;
      data = 32'hDEAD_BEEF; resp = 2'b01;
      axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
      while (!done && k < 40) begin
         hs_ar = axi.arvalid && axi.arready;
         hs_r  = axi.rvalid && axi.rready;
         if (hs_r) begin data = axi.rdata; resp = axi.rresp; end
         @(posedge clk); k++;
         @(negedge clk);
         if (hs_ar) axi.arvalid = 1'b0;
         if (hs_r) begin axi.rready = 1'b0; done = 1; end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL read_timeout addr=%h: no R response within 40 cycles", addr);
         axi.arvalid = 1'b0; axi.rready = 1'b0;
      end
   endtask

   task automatic test_reset();
      logic [7:0] outs;
      axi.awaddr = '0; axi.awvalid = 0; axi.wdata = '0; axi.wvalid = 0; axi.bready = 0;
      axi.araddr = '0; axi.arvalid = 0; axi.rready = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      outs = {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, reg_we, busy, 1'b0};
      tests++;
      if (outs !== 8'h00 || axi.rdata !== 32'h0 || axi.bresp !== 2'b00 || reg_wdata !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs got=%b rdata=%h bresp=%b wdata=%h want all zero",
                  outs, axi.rdata, axi.bresp, reg_wdata);
      end
      rst = 1'b0;
      #1;
      tests++;
      if ({axi.awready, axi.arready} !== 2'b00) begin
         fails++;
         $display("FAIL ready_before_clock got=%b want=00", {axi.awready, axi.arready});
      end
      @(negedge clk);
      tests++;
      if ({axi.awready, axi.arready} !== 2'b11) begin
         fails++;
         $display("FAIL ready_after_clock got=%b want=11", {axi.awready, axi.arready});
      end
   endtask

   task automatic test_write_basic();
      logic [1:0]  resp;
      logic [31:0] rd;
      int          aw_e, b_e, we0, f0;
      we0 = we_cnt; f0 = busy_falls;
      axi_write(7'h10, 32'hA5A5_0001, resp, aw_e, b_e);
      // AW, W and B accept on three consecutive edges with bready held high.
      tests++;
      if (b_e - aw_e !== 2) begin
         fails++; $display("FAIL b_latency got=%0d edges want=2", b_e - aw_e);
      end
      tests++;
      if (resp !== 2'b00) begin
         fails++; $display("FAIL write_bresp got=%b want=00", resp);
      end
      tests++;
      if (we_cnt !== we0 + 1 || we_idx !== 5'd4 || we_data !== 32'hA5A5_0001) begin
         fails++;
         $display("FAIL reg_strobe count=%0d idx=%0d data=%h want count=%0d idx=4 data=a5a50001",
                  we_cnt - we0, we_idx, we_data, 1);
      end
      repeat (12) @(negedge clk);
      tests++;
      if (busy_falls !== f0 + 1 || busy_len !== 8) begin
         fails++;
         $display("FAIL busy_length runs=%0d len=%0d want runs=1 len=8", busy_falls - f0, busy_len);
      end
      axi_read(7'h10, rd, resp);
      tests++;
      if (rd !== 32'hA5A5_0001 || resp !== 2'b00) begin
         fails++; $display("FAIL readback got=%h/%b want=a5a50001/00", rd, resp);
      end
   endtask

   task automatic test_poll_status();
      logic [1:0]  resp;
      logic [31:0] rd, first_rd;
      int          aw_e, b_e, polls;
      status = 32'hFFFF_FFFF;
      axi_write(7'h14, 32'h0000_00C3, resp, aw_e, b_e);
      polls = 0;
      first_rd = 32'h0;
      rd = 32'h0;
      do begin
         axi_read(7'h24, rd, resp);
         if (polls == 0) first_rd = rd;
         polls++;
      end while (rd[11:10] != 2'b00 && polls < 30);
      tests++;
      if (first_rd !== 32'hFFFF_F7FF) begin
         fails++; $display("FAIL poll_busy got=%h want=fffff7ff", first_rd);
      end
      tests++;
      if (rd !== 32'hFFFF_F3FF || polls < 2 || polls >= 30) begin
         fails++; $display("FAIL poll_exit got=%h after %0d polls want=fffff3ff within 2..29", rd, polls);
      end
   endtask

   task automatic test_overrun();
      logic [1:0]  resp;
      logic [31:0] rd;
      int          aw_e, b_e;
      status = 32'h1234_5678;
      axi_write(7'h20, 32'h0000_0011, resp, aw_e, b_e);
      axi_write(7'h28, 32'h0000_0022, resp, aw_e, b_e);
      axi_read(7'h24, rd, resp);
      tests++;
      if (rd !== 32'h1234_5E78 || resp !== 2'b00) begin
         fails++; $display("FAIL overrun_flag got=%h/%b want=12345e78/00", rd, resp);
      end
      repeat (12) @(negedge clk);
      axi_read(7'h24, rd, resp);
      tests++;
      if (rd !== 32'h1234_5278) begin
         fails++; $display("FAIL flags_cleared got=%h want=12345278", rd);
      end
      // Reload three cycles into the first run: 3 + 8 busy cycles back to back.
      tests++;
      if (busy_len !== 11) begin
         fails++; $display("FAIL busy_reload_len got=%0d want=11", busy_len);
      end
   endtask

   task automatic test_errors();
      logic [1:0]  resp;
      logic [31:0] rd;
      int          aw_e, b_e, we0;
      we0 = we_cnt;
      axi_write(7'h24, 32'hFFFF_FFFF, resp, aw_e, b_e);
      tests++;
      if (resp !== 2'b10 || we_cnt !== we0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL status_write resp=%b strobes=%0d busy=%b want 10/0/0", resp, we_cnt - we0, busy);
      end
      axi_write(7'h7C, 32'h0BAD_F00D, resp, aw_e, b_e);
      tests++;
      if (resp !== 2'b11 || we_cnt !== we0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL decerr_write resp=%b strobes=%0d busy=%b want 11/0/0", resp, we_cnt - we0, busy);
      end
      axi_read(7'h7C, rd, resp);
      tests++;
      if (rd !== 32'h0 || resp !== 2'b11) begin
         fails++; $display("FAIL decerr_read got=%h/%b want=00000000/11", rd, resp);
      end
   endtask

   task automatic test_backpressure();
      bit          hs_aw, hs_w, hs_ar, stable;
      logic [1:0]  resp;
      logic [31:0] rd;
      int          k;
      axi.awaddr = 7'h18; axi.wdata = 32'h5555_AAAA; axi.awvalid = 1; axi.wvalid = 1; axi.bready = 0;
      axi.araddr = 7'h10; axi.arvalid = 1; axi.rready = 0;
      k = 0;
      while (!(axi.bvalid && axi.rvalid) && k < 20) begin
         hs_aw = axi.awvalid && axi.awready;
         hs_w  = axi.wvalid && axi.wready;
         hs_ar = axi.arvalid && axi.arready;
         @(posedge clk); @(negedge clk); k++;
         if (hs_aw) axi.awvalid = 0;
         if (hs_w)  axi.wvalid = 0;
         if (hs_ar) axi.arvalid = 0;
      end
      tests++;
      if (!(axi.bvalid && axi.rvalid)) begin
         fails++; $display("FAIL bp_setup bvalid=%b rvalid=%b want 1/1", axi.bvalid, axi.rvalid);
      end
      // New requests are offered but must not be taken while responses stall.
      axi.awaddr = 7'h1C; axi.awvalid = 1; axi.araddr = 7'h14; axi.arvalid = 1;
      stable = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (axi.bvalid !== 1 || axi.bresp !== 2'b00 || axi.rvalid !== 1 ||
             axi.rdata !== 32'hA5A5_0001 || axi.rresp !== 2'b00 ||
             axi.awready !== 0 || axi.arready !== 0)
            stable = 0;
      end
      tests++;
      if (!stable) begin
         fails++;
         $display("FAIL bp_hold bvalid=%b rvalid=%b rdata=%h awready=%b arready=%b want 1/1/a5a50001/0/0",
                  axi.bvalid, axi.rvalid, axi.rdata, axi.awready, axi.arready);
      end
      axi.awvalid = 0; axi.arvalid = 0;
      axi.bready = 1; axi.rready = 1;
      @(negedge clk);
      axi.bready = 0; axi.rready = 0;
      tests++;
      if ({axi.bvalid, axi.rvalid, axi.awready, axi.arready} !== 4'b0011) begin
         fails++;
         $display("FAIL bp_release got=%b want=0011", {axi.bvalid, axi.rvalid, axi.awready, axi.arready});
      end
      axi_read(7'h18, rd, resp);
      tests++;
      if (rd !== 32'h5555_AAAA) begin
         fails++; $display("FAIL bp_write_data got=%h want=5555aaaa", rd);
      end
   endtask

   task automatic test_reset_midflight();
      bit          hs_aw, hs_ar;
      logic [1:0]  resp;
      logic [31:0] rd;
      int          aw_e, b_e, k;
      axi.awaddr = 7'h0C; axi.awvalid = 1; axi.wvalid = 0; axi.bready = 0;
      axi.araddr = 7'h10; axi.arvalid = 1; axi.rready = 0;
      k = 0;
      while (!(axi.wready && axi.rvalid) && k < 20) begin
         hs_aw = axi.awvalid && axi.awready;
         hs_ar = axi.arvalid && axi.arready;
         @(posedge clk); @(negedge clk); k++;
         if (hs_aw) axi.awvalid = 0;
         if (hs_ar) axi.arvalid = 0;
      end
      tests++;
      if (!(axi.wready && axi.rvalid)) begin
         fails++; $display("FAIL mid_setup wready=%b rvalid=%b want 1/1", axi.wready, axi.rvalid);
      end
      axi.awvalid = 0; axi.arvalid = 0;
      rst = 1'b1;
      #1;
      tests++;
      if ({axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, reg_we, busy} !== 7'b0 ||
          axi.rdata !== 32'h0) begin
         fails++;
         $display("FAIL async_reset outs=%b rdata=%h want all zero",
                  {axi.awready, axi.wready, axi.bvalid, axi.arready, axi.rvalid, reg_we, busy}, axi.rdata);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      axi_read(7'h10, rd, resp);
      tests++;
      if (rd !== 32'h0 || resp !== 2'b00) begin
         fails++; $display("FAIL regs_cleared got=%h/%b want=00000000/00", rd, resp);
      end
      axi_write(7'h0C, 32'h0000_1234, resp, aw_e, b_e);
      tests++;
      if (resp !== 2'b00) begin
         fails++; $display("FAIL post_reset_bresp got=%b want=00", resp);
      end
      axi_read(7'h0C, rd, resp);
      tests++;
      if (rd !== 32'h0000_1234) begin
         fails++; $display("FAIL post_reset_read got=%h want=00001234", rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_poll_status();
      test_overrun();
      test_errors();
      test_backpressure();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
